// File: rtl/flag_cond_unit.sv
// flag_cond_unit: NZCV flag register plus ARM condition / CBZ / CBNZ / B resolution, registered taken output.
// Optional macro FLAG_FWD_EN: B.cond sees same-cycle flag writes (zero-bubble SUBS -> B.cond).
`default_nettype none

module flag_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       negative,
  input  logic       zero,
  input  logic       overflow,
  input  logic       carry_out,
  input  logic       set_flags,
  input  logic       flag_logic,
  input  logic       br_valid,
  input  logic [1:0] br_kind,
  input  logic [3:0] cond,
  output logic       taken,
  output logic       taken_valid,
  output logic [3:0] flags
);

  localparam logic [1:0] KIND_BCOND = 2'b00;
  localparam logic [1:0] KIND_CBZ   = 2'b01;
  localparam logic [1:0] KIND_CBNZ  = 2'b10;
  localparam logic [1:0] KIND_B     = 2'b11;

  logic [3:0] flags_q;
  logic [3:0] flags_next;
  logic [3:0] eval_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_true;
  logic       decision;

  // Logical ops only define N and Z; C and V are cleared.
  assign flags_next = flag_logic ? {negative, zero, 2'b00}
                                 : {negative, zero, carry_out, overflow};

`ifdef FLAG_FWD_EN
  assign eval_flags = set_flags ? flags_next : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  assign {f_n, f_z, f_c, f_v} = eval_flags;

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = !f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = !f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = !f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = !f_v;
      4'b1000: cond_true = f_c && !f_z;
      4'b1001: cond_true = !f_c || f_z;
      4'b1010: cond_true = (f_n == f_v);
      4'b1011: cond_true = (f_n != f_v);
      4'b1100: cond_true = !f_z && (f_n == f_v);
      4'b1101: cond_true = f_z || (f_n != f_v);
      default: cond_true = 1'b1;
    endcase
  end

  // CBZ/CBNZ test the ALU zero output directly (ALU in pass-B mode).
  always_comb begin
    decision = 1'b0;
    case (br_kind)
      KIND_BCOND: decision = cond_true;
      KIND_CBZ:   decision = zero;
      KIND_CBNZ:  decision = !zero;
      KIND_B:     decision = 1'b1;
      default:    decision = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      taken       <= 1'b0;
      taken_valid <= 1'b0;
    end else begin
      if (set_flags) begin
        flags_q <= flags_next;
      end
      taken_valid <= br_valid;
      if (br_valid) begin
        taken <= decision;
      end
    end
  end

  assign flags = flags_q;

endmodule

`default_nettype wire
